// File: rtl/image_screen_anim.sv
// Scaled, animated splash image with palette lookup and fade-in/out sequencing.
// Define IMAGE_SCREEN_FADE_EN to enable brightness fading; otherwise cut in/out.
module image_screen_anim #(
   parameter int IMG_W       = 100,
   parameter int IMG_H       = 15,
   parameter int FRAMES      = 4,
   parameter int PAL_BITS    = 2,
   parameter int ADDR_W      = 13,
   parameter int ANIM_HOLD   = 8,
   parameter int HOLD_FRAMES = 120,
   parameter int FADE_STEP   = 2
) (
   input  logic                vga_clk,
   input  logic                reset_n,
   input  logic [9:0]          DrawX,
   input  logic [9:0]          DrawY,
   input  logic                blank,
   input  logic                start,
   input  logic                stop,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [PAL_BITS-1:0] rom_q,
   output logic [PAL_BITS-1:0] pal_index,
   input  logic [3:0]          pal_r,
   input  logic [3:0]          pal_g,
   input  logic [3:0]          pal_b,
   output logic [3:0]          red,
   output logic [3:0]          green,
   output logic [3:0]          blue,
   output logic                busy,
   output logic                done
);

   localparam int FS_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam logic [31:0] IW       = 32'(IMG_W);
   localparam logic [31:0] FRAME_SZ = 32'(IMG_W * IMG_H);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_FIN  = 3'd1;
   localparam logic [2:0] S_SHOW = 3'd2;
   localparam logic [2:0] S_FOUT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

`ifdef IMAGE_SCREEN_FADE_EN
   localparam logic [2:0] S_ENTER = S_FIN;
   localparam logic [2:0] S_LEAVE = S_FOUT;
`else
   localparam logic [2:0] S_ENTER = S_SHOW;
   localparam logic [2:0] S_LEAVE = S_DONE;
`endif

   logic [2:0]      state;
   logic [2:0]      state_n;
   logic [15:0]     tick_cnt;
   logic [15:0]     anim_cnt;
   logic [FS_W-1:0] frame_sel;
   logic [4:0]      level;
   logic            blank_d;
   logic            tick_cond;
   logic            tick_q;
   logic            frame_tick;
   logic            step_hit;
   logic            hold_hit;
   logic            in_view;
   logic [31:0]     x_col;
   logic [31:0]     y_row;

   // Nearest-lower texel for a 640x480 screen stretched over the image.
   assign x_col   = (32'(DrawX) * IW) / 32'd640;
   assign y_row   = (32'(DrawY) * 32'(IMG_H)) / 32'd480;
   assign in_view = (DrawX < 10'd640) && (DrawY < 10'd480);
   assign rom_addr = in_view
      ? ADDR_W'(32'(frame_sel) * FRAME_SZ + y_row * IW + x_col)
      : '0;

   assign pal_index = rom_q;

   assign tick_cond  = (DrawX == 10'd0) && (DrawY == 10'd480);
   assign frame_tick = tick_cond & ~tick_q;

   assign step_hit = frame_tick
                  && (tick_cnt == 16'(FADE_STEP - 1));
   assign hold_hit = frame_tick && (HOLD_FRAMES != 0)
                  && (tick_cnt == 16'(HOLD_FRAMES - 1));

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: if (start) state_n = S_ENTER;
         S_FIN: begin
            if (stop)
               state_n = S_FOUT;
            else if (step_hit && level == 5'd15)
               state_n = S_SHOW;
         end
         S_SHOW: if (stop || hold_hit) state_n = S_LEAVE;
         S_FOUT: begin
            if (level == 5'd0 || (step_hit && level == 5'd1))
               state_n = S_DONE;
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         tick_q   <= 1'b0;
         tick_cnt <= '0;
      end else begin
         state  <= state_n;
         tick_q <= tick_cond;
         if (state_n != state)
            tick_cnt <= '0;
         else if (step_hit && (state == S_FIN || state == S_FOUT))
            tick_cnt <= '0;
         else if (frame_tick && state != S_IDLE)
            tick_cnt <= tick_cnt + 16'd1;
      end
   end

   // Animation only steps on frame_tick, i.e. during vertical blank.
   always_ff @(posedge vga_clk) begin
      if (!reset_n || state == S_IDLE) begin
         anim_cnt  <= '0;
         frame_sel <= '0;
      end else begin
         if (frame_tick) begin
            if (anim_cnt == 16'(ANIM_HOLD - 1)) begin
               anim_cnt  <= '0;
               frame_sel <= (frame_sel == FS_W'(FRAMES - 1))
                          ? '0 : frame_sel + FS_W'(1);
            end else begin
               anim_cnt <= anim_cnt + 16'd1;
            end
         end
         if (state_n != state)
            anim_cnt <= '0;
      end
   end

`ifdef IMAGE_SCREEN_FADE_EN
   always_ff @(posedge vga_clk) begin
      if (!reset_n || state == S_IDLE)
         level <= 5'd0;
      else if (state == S_FIN && !stop && step_hit)
         level <= level + 5'd1;
      else if (state == S_FOUT && step_hit && level != 5'd0)
         level <= level - 5'd1;
   end
`else
   assign level = (state == S_IDLE) ? 5'd0 : 5'd16;
`endif

   // blank_d lines up with rom_q; level 16 passes the colour unchanged.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         blank_d <= 1'b0;
         red     <= '0;
         green   <= '0;
         blue    <= '0;
      end else begin
         blank_d <= blank;
         red   <= blank_d ? 4'(({5'd0, pal_r} * {4'd0, level}) >> 4) : '0;
         green <= blank_d ? 4'(({5'd0, pal_g} * {4'd0, level}) >> 4) : '0;
         blue  <= blank_d ? 4'(({5'd0, pal_b} * {4'd0, level}) >> 4) : '0;
      end
   end

endmodule

// File: tb/tb_image_screen_anim.sv
// Bench for image_screen_anim: ROM/palette models, pixel scoreboard, FSM sequences.
// Covers both builds; the fade-specific sequences need IMAGE_SCREEN_FADE_EN.
module tb_image_screen_anim;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank;
      int         addr;
   } vec_t;

   typedef struct {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } px_t;

   localparam int NV = 12;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic        blank = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [12:0] rom_addr;
   logic [1:0]  rom_q = '0;
   logic [1:0]  pal_index;
   logic [3:0]  pal_r, pal_g, pal_b;
   logic [3:0]  red, green, blue;
   logic        busy, done;

   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   d0;
   vec_t vecs[NV];
   px_t  sb[$];

   always #5 vga_clk = ~vga_clk;

   image_screen_anim dut (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .start(start), .stop(stop),
      .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
      .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
      .red(red), .green(green), .blue(blue),
      .busy(busy), .done(done)
   );

   function automatic logic [1:0] rom_fn(input logic [12:0] a);
      logic [1:0] t;
      t = a[1:0];
      return t ^ 2'b10;
   endfunction

   function automatic int pal_c(input int ch, input logic [1:0] idx);
      int t[3][4];
      t = '{'{1, 4, 15, 10}, '{2, 9, 8, 5}, '{3, 12, 0, 14}};
      return t[ch][idx];
   endfunction

   always @(posedge vga_clk) rom_q <= rom_fn(rom_addr);

   always_comb begin
      pal_r = 4'(pal_c(0, pal_index));
      pal_g = 4'(pal_c(1, pal_index));
      pal_b = 4'(pal_c(2, pal_index));
   end

   always @(negedge vga_clk) if (done === 1'b1) done_cnt++;

   function automatic px_t expect_px(input vec_t v, input int lvl);
      px_t p;
      logic [1:0] idx;
      idx = rom_fn(13'(v.addr));
      p.r = v.blank ? 4'(pal_c(0, idx) * lvl / 16) : 4'd0;
      p.g = v.blank ? 4'(pal_c(1, idx) * lvl / 16) : 4'd0;
      p.b = v.blank ? 4'(pal_c(2, idx) * lvl / 16) : 4'd0;
      return p;
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge vga_clk);
   endtask

   task automatic tick();
      @(negedge vga_clk) DrawY = 10'd480;
      @(negedge vga_clk) DrawY = 10'd0;
      @(negedge vga_clk);
   endtask

   task automatic long_tick();
      @(negedge vga_clk) DrawY = 10'd480;
      repeat (6) @(negedge vga_clk);
      DrawY = 10'd0;
      @(negedge vga_clk);
   endtask

   task automatic pulse(input logic s, input logic p);
      @(negedge vga_clk);
      start = s;
      stop  = p;
      @(negedge vga_clk);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic stream(input int lvl);
      px_t e;
      for (int i = 0; i < NV + 2; i++) begin
         @(negedge vga_clk);
         if (i >= 2) begin
            e = sb.pop_front();
            check("px_red", red, e.r);
            check("px_green", green, e.g);
            check("px_blue", blue, e.b);
         end
         if (i < NV) begin
            DrawX = vecs[i].x;
            DrawY = vecs[i].y;
            blank = vecs[i].blank;
            #1 check("rom_addr", rom_addr, vecs[i].addr);
            sb.push_back(expect_px(vecs[i], lvl));
         end
      end
      DrawX = '0;
      DrawY = '0;
      blank = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{10'd639,  10'd479,  1'b1, 1499};
      vecs[1]  = '{10'd640,  10'd0,    1'b1, 0};
      vecs[2]  = '{10'd0,    10'd0,    1'b1, 0};
      vecs[3]  = '{10'd320,  10'd240,  1'b1, 750};
      vecs[4]  = '{10'd320,  10'd240,  1'b0, 750};
      vecs[5]  = '{10'd7,    10'd32,   1'b1, 101};
      vecs[6]  = '{10'd6,    10'd31,   1'b1, 0};
      vecs[7]  = '{10'd5,    10'd480,  1'b1, 0};
      vecs[8]  = '{10'd1023, 10'd1023, 1'b1, 0};
      vecs[9]  = '{10'd639,  10'd0,    1'b1, 99};
      vecs[10] = '{10'd0,    10'd479,  1'b1, 1400};
      vecs[11] = '{10'd64,   10'd32,   1'b0, 110};

      cyc(3);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_red", red, 0);
      check("rst_green", green, 0);
      check("rst_blue", blue, 0);
      check("rst_addr", rom_addr, 0);
      reset_n = 1'b1;
      blank = 1'b1;

      stream(0);
      check("idle_busy", busy, 0);

      pulse(1'b0, 1'b1);
      cyc(2);
      check("stop_in_idle", busy, 0);

      pulse(1'b1, 1'b1);
      check("start_prio", busy, 1);
      cyc(3);
      check("start_prio_hold", busy, 1);
      check("no_done", done, 0);

`ifdef IMAGE_SCREEN_FADE_EN
      repeat (16) tick();
      check("fade_l8", red, 7);
      repeat (16) tick();
      check("fade_l16", red, 15);
      repeat (2) tick();
      check("show_l16", red, 15);
`else
      cyc(2);
      check("show_l16", red, 15);
`endif
      stream(16);

      d0 = done_cnt;
`ifdef IMAGE_SCREEN_FADE_EN
      pulse(1'b0, 1'b1);
      check("fout_busy", busy, 1);
      repeat (16) tick();
      check("fout_l8", red, 7);
      repeat (15) tick();
      check("fout_l1_busy", busy, 1);
      check("fout_l1_nodone", done_cnt, d0);
      tick();
      check("fout_end_busy", busy, 0);
      check("fout_done_cnt", done_cnt, d0 + 1);
`else
      pulse(1'b0, 1'b1);
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      cyc(1);
      check("done_clear", done, 0);
      check("done_idle", busy, 0);
      check("done_cnt", done_cnt, d0 + 1);
`endif

      pulse(1'b1, 1'b0);
      check("anim_t0", rom_addr, 0);
      long_tick();
      repeat (6) tick();
      check("anim_t7_edge", rom_addr, 0);
      tick();
      check("anim_t8", rom_addr, 1500);
      repeat (8) tick();
      check("anim_t16", rom_addr, 3000);
      repeat (8) tick();
      check("anim_t24", rom_addr, 4500);
      repeat (8) tick();
      check("anim_t32", rom_addr, 0);
      repeat (8) tick();
      check("pre_rst_addr", rom_addr, 1500);
      check("pre_rst_green", green, 8);

      d0 = done_cnt;
      @(negedge vga_clk) reset_n = 1'b0;
      @(negedge vga_clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_red", red, 0);
      check("mid_rst_green", green, 0);
      check("mid_rst_addr", rom_addr, 0);
      reset_n = 1'b1;
      cyc(3);
      check("mid_rst_nodone", done_cnt, d0);
      check("mid_rst_idle", busy, 0);

      d0 = done_cnt;
`ifdef IMAGE_SCREEN_FADE_EN
      pulse(1'b1, 1'b0);
      repeat (10) tick();
      check("early_l5", red, 4);
      pulse(1'b0, 1'b1);
      check("early_busy", busy, 1);
      repeat (4) tick();
      check("early_l3", red, 2);
      repeat (5) tick();
      check("early_l1_busy", busy, 1);
      check("early_nodone", done_cnt, d0);
      tick();
      check("early_end_busy", busy, 0);
      check("early_done_cnt", done_cnt, d0 + 1);
`else
      pulse(1'b1, 1'b0);
      repeat (119) tick();
      check("hold_119_busy", busy, 1);
      check("hold_119_nodone", done_cnt, d0);
      tick();
      check("hold_end_busy", busy, 0);
      check("hold_done_cnt", done_cnt, d0 + 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
